// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: command byte map, reply codes, state encoding and one-hot command indices
package uart_cmd_pkg;
  localparam logic [7:0] CH_RUN    = 8'h52;
  localparam logic [7:0] CH_STOP   = 8'h53;
  localparam logic [7:0] CH_CLEAR  = 8'h43;
  localparam logic [7:0] CH_MODE   = 8'h4D;
  localparam logic [7:0] CH_DISP   = 8'h4E;
  localparam logic [7:0] CH_SEC    = 8'h73;
  localparam logic [7:0] CH_MIN    = 8'h6D;
  localparam logic [7:0] CH_HOUR   = 8'h68;
  localparam logic [7:0] CH_STATUS = 8'h3F;
  localparam logic [7:0] CH_DIG0   = 8'h30;
  localparam logic [7:0] CH_DIG9   = 8'h39;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] STATUS_BASE = 8'h30;
  localparam logic [7:0] NAK         = 8'h21;
  localparam int CMD_RUN    = 0;
  localparam int CMD_STOP   = 1;
  localparam int CMD_CLEAR  = 2;
  localparam int CMD_MODE   = 3;
  localparam int CMD_DISP   = 4;
  localparam int CMD_SEC    = 5;
  localparam int CMD_MIN    = 6;
  localparam int CMD_HOUR   = 7;
  localparam int CMD_STATUS = 8;
  localparam int NCMD       = 9;
  typedef enum logic {IDLE = 1'b0, REPEAT = 1'b1} state_e;
endpackage

// File: rtl/uart_cmd_lut.sv
// uart_cmd_lut: combinational classification of a received byte
module uart_cmd_lut
  import uart_cmd_pkg::*;
(
  input  logic [7:0]      byte_i,
  output logic [NCMD-1:0] cmd_o,
  output logic            is_digit_o,
  output logic [3:0]      digit_o,
  output logic            is_ignore_o,
  output logic            is_unknown_o
);
  always_comb begin
    cmd_o = '0;
    cmd_o[CMD_RUN]    = byte_i == CH_RUN;
    cmd_o[CMD_STOP]   = byte_i == CH_STOP;
    cmd_o[CMD_CLEAR]  = byte_i == CH_CLEAR;
    cmd_o[CMD_MODE]   = byte_i == CH_MODE;
    cmd_o[CMD_DISP]   = byte_i == CH_DISP;
    cmd_o[CMD_SEC]    = byte_i == CH_SEC;
    cmd_o[CMD_MIN]    = byte_i == CH_MIN;
    cmd_o[CMD_HOUR]   = byte_i == CH_HOUR;
    cmd_o[CMD_STATUS] = byte_i == CH_STATUS;
    is_digit_o   = byte_i >= CH_DIG0 && byte_i <= CH_DIG9;
    digit_o      = byte_i[3:0];
    is_ignore_o  = byte_i == CH_CR || byte_i == CH_LF;
    is_unknown_o = !(|cmd_o || is_digit_o || is_ignore_o);
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: ASCII command bytes to control pulses, with echo/status/NAK replies
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter bit ECHO_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic       i_mode_sel,
  input  logic       i_is_running,
  input  logic       i_fnd_mode,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_display_mode,
  output logic       o_sec_plus,
  output logic       o_min_plus,
  output logic       o_hour_plus,
  output logic [7:0] o_err_cnt
);
  logic [NCMD-1:0] cmd;
  logic            is_dig, is_ign, is_unk, accept, reply;
  logic [3:0]      dig;
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d, prefix_q, prefix_d;
  logic            phase_q, phase_d, tx_valid_q, tx_valid_d;
  logic [7:0]      inc_q, inc_d, pulse_q, pulse_d, tx_data_q, tx_data_d, err_q, err_d;

  uart_cmd_lut u_lut (
    .byte_i      (i_rx_data),
    .cmd_o       (cmd),
    .is_digit_o  (is_dig),
    .digit_o     (dig),
    .is_ignore_o (is_ign),
    .is_unknown_o(is_unk)
  );

  assign o_rx_ready = state_q == IDLE && !tx_valid_q;
  assign accept     = i_rx_valid && o_rx_ready;
  assign reply      = cmd[CMD_STATUS] || is_unk || (ECHO_EN && !is_ign);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    pulse_d    = '0;
    prefix_d   = prefix_q;
    tx_valid_d = tx_valid_q && !i_tx_ready;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    // phase_q=1 marks a pulse cycle; cnt_q counts pulses still owed after the current one
    if (state_q == REPEAT) begin
      pulse_d = phase_q ? inc_q : '0;
      cnt_d   = phase_q ? cnt_q - 4'd1 : cnt_q;
      phase_d = !phase_q && cnt_q != 4'd0;
      state_d = (!phase_q && cnt_q == 4'd0) ? IDLE : REPEAT;
    end
    if (accept) begin
      pulse_d  = cmd[CMD_HOUR:CMD_RUN];
      prefix_d = is_dig ? dig : 4'd0;
      if (|cmd[CMD_HOUR:CMD_SEC] && prefix_q >= 4'd2) begin
        state_d = REPEAT;
        cnt_d   = prefix_q - 4'd1;
        phase_d = 1'b0;
        inc_d   = cmd[CMD_HOUR:CMD_RUN];
      end
      tx_valid_d = reply;
      tx_data_d  = !reply ? tx_data_q :
                   cmd[CMD_STATUS] ? (STATUS_BASE | {5'd0, i_fnd_mode, i_is_running, i_mode_sel}) :
                   is_unk ? NAK : i_rx_data;
      err_d      = (is_unk && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      inc_q      <= '0;
      pulse_q    <= '0;
      prefix_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      pulse_q    <= pulse_d;
      prefix_q   <= prefix_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end

  assign o_tx_valid     = tx_valid_q;
  assign o_tx_data      = tx_data_q;
  assign o_err_cnt      = err_q;
  assign o_run          = pulse_q[CMD_RUN];
  assign o_stop         = pulse_q[CMD_STOP];
  assign o_clear        = pulse_q[CMD_CLEAR];
  assign o_mode         = pulse_q[CMD_MODE];
  assign o_display_mode = pulse_q[CMD_DISP];
  assign o_sec_plus     = pulse_q[CMD_SEC];
  assign o_min_plus     = pulse_q[CMD_MIN];
  assign o_hour_plus    = pulse_q[CMD_HOUR];
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed and random bytes into an echo and a no-echo decoder, checked
// against a per-byte behavioural model of pulses, replies, ready timing and error count
module tb_uart_cmd_decoder;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_data;
  logic v_e, v_n, tx_ready, mode_sel, is_run, fnd, sel;
  logic e_rdy, e_txv, n_rdy, n_txv;
  logic [7:0] e_txd, e_err, n_txd, n_err, e_pul, n_pul;
  logic [7:0] pul, txd, errc;
  logic txv, rdy;
  int total = 0, bad = 0;
  int m_pre[2] = '{0, 0};
  int m_err[2] = '{0, 0};
  logic [7:0] cmds[8] = '{8'h52, 8'h53, 8'h43, 8'h4D, 8'h4E, 8'h73, 8'h6D, 8'h68};

  always #5 clk = ~clk;

  uart_cmd_decoder #(.ECHO_EN(1'b1)) u_e (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(v_e), .o_rx_ready(e_rdy),
    .o_tx_data(e_txd), .o_tx_valid(e_txv), .i_tx_ready(tx_ready),
    .i_mode_sel(mode_sel), .i_is_running(is_run), .i_fnd_mode(fnd),
    .o_run(e_pul[0]), .o_stop(e_pul[1]), .o_clear(e_pul[2]), .o_mode(e_pul[3]),
    .o_display_mode(e_pul[4]), .o_sec_plus(e_pul[5]), .o_min_plus(e_pul[6]),
    .o_hour_plus(e_pul[7]), .o_err_cnt(e_err)
  );

  uart_cmd_decoder #(.ECHO_EN(1'b0)) u_n (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(v_n), .o_rx_ready(n_rdy),
    .o_tx_data(n_txd), .o_tx_valid(n_txv), .i_tx_ready(tx_ready),
    .i_mode_sel(mode_sel), .i_is_running(is_run), .i_fnd_mode(fnd),
    .o_run(n_pul[0]), .o_stop(n_pul[1]), .o_clear(n_pul[2]), .o_mode(n_pul[3]),
    .o_display_mode(n_pul[4]), .o_sec_plus(n_pul[5]), .o_min_plus(n_pul[6]),
    .o_hour_plus(n_pul[7]), .o_err_cnt(n_err)
  );

  assign pul  = sel ? n_pul : e_pul;
  assign txd  = sel ? n_txd : e_txd;
  assign txv  = sel ? n_txv : e_txv;
  assign rdy  = sel ? n_rdy : e_rdy;
  assign errc = sel ? n_err : e_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cmd_idx(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (cmds[i] == b) return i;
    return -1;
  endfunction

  function automatic bit is_digit_m(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  function automatic bit is_unk_m(input logic [7:0] b);
    return cmd_idx(b) < 0 && !is_digit_m(b) && b != 8'h0D && b != 8'h0A && b != 8'h3F;
  endfunction

  always @(negedge clk)
    if (!rst) chk("pulse_exclusive", ($countones(e_pul) > 1) || ($countones(n_pul) > 1), 0);

  // one byte into DUT s (0 echo, 1 no echo); transmitter becomes ready after hold cycles
  task automatic xfer(input bit s, input logic [7:0] b, input int hold);
    int idx, p, ecnt, erep, erdy, rdy_at, rep_o, w;
    logic [31:0] at_o, at_e;
    logic [7:0] mask_o, mask_e;
    bit stable;
    sel = s;
    tx_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!rdy && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("rx_ready_wait", rdy, 1);
    idx = cmd_idx(b);
    p = m_pre[s];
    ecnt = idx < 0 ? 0 : (idx >= 5 && p >= 2) ? p : 1;
    mask_e = idx < 0 ? 8'h00 : 8'h01 << idx;
    at_e = '0;
    for (int i = 0; i < ecnt; i++) at_e[2*i+1] = 1'b1;
    erep = b == 8'h3F ? 'h30 + 4 * fnd + 2 * is_run + mode_sel :
           is_unk_m(b) ? 'h21 :
           (s == 1'b0 && b != 8'h0D && b != 8'h0A) ? int'(b) : -1;
    erdy = 1;
    if (ecnt > 1) erdy = 2 * ecnt;
    if (erep >= 0 && hold + 2 > erdy) erdy = hold + 2;
    m_pre[s] = is_digit_m(b) ? int'(b) - 'h30 : 0;
    if (is_unk_m(b) && m_err[s] < 255) m_err[s]++;
    rx_data = b;
    v_e = !s;
    v_n = s;
    @(posedge clk);
    #1 v_e = 1'b0;
    v_n = 1'b0;
    at_o = '0;
    mask_o = '0;
    rep_o = -1;
    stable = 1'b1;
    rdy_at = -1;
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      if (|pul) at_o[k] = 1'b1;
      mask_o |= pul;
      if (txv) begin
        if (rep_o < 0) rep_o = int'(txd);
        else if (int'(txd) != rep_o) stable = 1'b0;
      end
      if (rdy && rdy_at < 0) rdy_at = k;
      tx_ready = k > hold;
    end
    chk($sformatf("pulse_which[%h]", b), mask_o, mask_e);
    chk($sformatf("pulse_timing[%h]", b), at_o, at_e);
    chk($sformatf("reply[%h]", b), rep_o, erep);
    chk($sformatf("reply_stable[%h]", b), stable, 1);
    chk($sformatf("rx_ready_return[%h]", b), rdy_at, erdy);
    chk($sformatf("err_cnt[%h]", b), errc, m_err[s]);
  endtask

  initial begin
    logic [7:0] b, bb[4];
    int bi[4], cnt, r;
    bb = '{8'h52, 8'h53, 8'h43, 8'h4E};
    bi = '{0, 1, 2, 4};
    rst = 1'b1;
    v_e = 1'b0;
    v_n = 1'b0;
    rx_data = '0;
    tx_ready = 1'b0;
    mode_sel = 1'b0;
    is_run = 1'b0;
    fnd = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulses", {e_pul, n_pul}, 0);
    chk("rst_tx_valid", {e_txv, n_txv}, 0);
    chk("rst_tx_data", e_txd, 8'h00);
    chk("rst_err_cnt", e_err, 0);
    chk("rst_rx_ready", {e_rdy, n_rdy}, 2'b11);
    rst = 1'b0;
    xfer(0, 8'h52, 0);
    xfer(1, 8'h33, 0);
    xfer(1, 8'h73, 0);
    mode_sel = 1'b1;
    is_run = 1'b1;
    fnd = 1'b0;
    xfer(0, 8'h3F, 10);
    repeat (3) xfer(0, 8'h7A, 0);
    for (int i = 0; i < 256; i++) begin
      do b = 8'($urandom); while (!is_unk_m(b));
      xfer(0, b, 0);
    end
    xfer(0, 8'h35, 0);
    xfer(0, 8'h43, 0);
    xfer(0, 8'h68, 0);
    // back-to-back commands on the no-echo decoder
    sel = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("b2b_pulse", n_pul, 8'h01 << bi[i-1]);
      if (i < 4) begin
        chk("b2b_ready", n_rdy, 1);
        rx_data = bb[i];
        v_n = 1'b1;
      end else v_n = 1'b0;
    end
    m_pre[1] = 0;
    // reset during a '9','m' repeat with the echo still pending
    xfer(0, 8'h39, 0);
    sel = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    rx_data = 8'h6D;
    v_e = 1'b1;
    @(posedge clk);
    #1 v_e = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cnt += int'(e_pul[6]);
    end
    chk("pre_rst_min_pulses", cnt, 2);
    chk("pre_rst_tx_pending", e_txv, 1);
    rst = 1'b1;
    #1 chk("rst_async_tx_valid", e_txv, 0);
    chk("rst_async_pulses", e_pul, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pre = '{0, 0};
    m_err = '{0, 0};
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt += int'(e_pul[6]);
    end
    chk("post_rst_min_pulses", cnt, 0);
    chk("post_rst_tx_valid", e_txv, 0);
    chk("post_rst_rx_ready", e_rdy, 1);
    chk("post_rst_err_cnt", e_err, 0);
    xfer(0, 8'h68, 0);
    // random mix of commands, digits, status, CR/LF and arbitrary bytes
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      b = r < 5 ? cmds[$urandom_range(0, 7)] :
          r < 7 ? 8'(8'h30 + $urandom_range(0, 9)) :
          r == 7 ? 8'h3F :
          r == 8 ? ($urandom_range(0, 1) ? 8'h0D : 8'h0A) : 8'($urandom);
      mode_sel = 1'($urandom);
      is_run = 1'($urandom);
      fnd = 1'($urandom);
      xfer(1'($urandom), b, $urandom_range(0, 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
